// File: rtl/dds_cfg_scheduler_pkg.sv
// Shared definitions for the DDS configuration scheduler.
//   - waveform codes and field limits
//   - FSM state encoding
//   - packed configuration record (shadow and live copies use the same layout)
//   - wrap-around increment helpers for the wave and amplitude fields
package dds_cfg_scheduler_pkg;

    localparam int          ADDR_W     = 9;
    localparam logic [1:0]  WAVE_SIN   = 2'd0;
    localparam logic [1:0]  WAVE_SAW   = 2'd1;
    localparam logic [1:0]  WAVE_SQR   = 2'd2;
    localparam logic [3:0]  AMP_MIN    = 4'd1;
    localparam logic [3:0]  AMP_MAX    = 4'd15;
    localparam logic [ADDR_W-1:0] PHASE_STEP = 9'd64;

    localparam int KEY_W = 0;
    localparam int KEY_A = 1;
    localparam int KEY_P = 2;
    localparam int KEY_F = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]        wave;
        logic [3:0]        amp;
        logic [5:0]        freq;
        logic [ADDR_W-1:0] phase;
    } cfg_t;

    localparam cfg_t CFG_RST = '{wave: WAVE_SIN, amp: AMP_MIN, freq: 6'd1, phase: '0};

    // sin -> saw -> square -> sin
    function automatic logic [1:0] next_wave(input logic [1:0] w);
        return (w == WAVE_SQR) ? WAVE_SIN : w + 2'd1;
    endfunction

    // 1..15, wrapping back to 1 (never 0, which would mute the output)
    function automatic logic [3:0] next_amp(input logic [3:0] a);
        return (a == AMP_MAX) ? AMP_MIN : a + 4'd1;
    endfunction

endpackage

// File: rtl/dds_cfg_scheduler_if.sv
// Key/config bus between the board keys, the DDS datapath and the scheduler.
//   key_w/a/p/f  raw active-high keys (asynchronous)
//   wrap_i       1-cycle period-boundary pulse from the datapath
//   wave_sel, amp, freq_step, phase_ofs  live generator settings
//   cfg_load     1-cycle pulse when the live settings change
//   cfg_pending  shadow settings not yet committed
// master: the scheduler; slave: keys + datapath side.
interface dds_cfg_scheduler_if;
    logic       key_w;
    logic       key_a;
    logic       key_p;
    logic       key_f;
    logic       wrap_i;
    logic [1:0] wave_sel;
    logic [3:0] amp;
    logic [5:0] freq_step;
    logic [8:0] phase_ofs;
    logic       cfg_load;
    logic       cfg_pending;

    modport master (
        input  key_w, key_a, key_p, key_f, wrap_i,
        output wave_sel, amp, freq_step, phase_ofs, cfg_load, cfg_pending
    );

    modport slave (
        output key_w, key_a, key_p, key_f, wrap_i,
        input  wave_sel, amp, freq_step, phase_ofs, cfg_load, cfg_pending
    );
endinterface

// File: rtl/dds_cfg_scheduler_key_debounce.sv
// Key debouncer: 2-flop synchroniser, stability counter, press pulse.
//   clk, rst_n  system clock, async active-low reset
//   key_i       raw asynchronous key level
//   prs_o       1-cycle pulse when the accepted level goes 0 -> 1
// The accepted level flips only after the synchronised level has differed
// from it for DEB_CYCLES consecutive cycles; any agreement restarts the count.
module dds_cfg_scheduler_key_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic prs_o
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             acc_q, acc_d;
    logic             prs_q, prs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        prs_d = 1'b0;
        if (sync2_q == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            cnt_d = '0;
            acc_d = ~acc_q;
            prs_d = ~acc_q;     // only the release -> press flip pulses
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b0;
            prs_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            prs_q   <= prs_d;
            cnt_q   <= cnt_d;
        end
    end

    assign prs_o = prs_q;
endmodule

// File: rtl/dds_cfg_scheduler.sv
// DDS configuration scheduler.
//   clk, rst_n  50 MHz clock, async active-low reset
//   bus         dds_cfg_scheduler_if.master: raw keys and wrap_i in,
//               live settings, cfg_load and cfg_pending out
// Key presses edit a shadow copy immediately; the live copy is only updated
// from the shadow at a waveform period boundary (wrap_i) or after TIMEOUT
// cycles, so the generator never changes mid-period.
module dds_cfg_scheduler
    import dds_cfg_scheduler_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int TIMEOUT    = 2_500_000,
    parameter int FREQ_MAX   = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dds_cfg_scheduler_if.master    bus
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [3:0]       key_raw;
    logic [3:0]       prs;
    logic             any_prs;
    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    cfg_t             shadow_q, shadow_d;
    cfg_t             live_q, live_d;
    logic             load_q, load_d;
    logic             pend_q, pend_d;

    assign key_raw = {bus.key_f, bus.key_p, bus.key_a, bus.key_w};

    for (genvar k = 0; k < 4; k++) begin : g_deb
        dds_cfg_scheduler_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .key_i (key_raw[k]),
            .prs_o (prs[k])
        );
    end

    assign any_prs = |prs;

    // Fields are independent, so simultaneous presses all land this cycle.
    always_comb begin
        shadow_d = shadow_q;
        if (prs[KEY_W]) shadow_d.wave  = next_wave(shadow_q.wave);
        if (prs[KEY_A]) shadow_d.amp   = next_amp(shadow_q.amp);
        if (prs[KEY_F]) shadow_d.freq  = (shadow_q.freq == 6'(FREQ_MAX)) ? 6'd1
                                                                         : shadow_q.freq + 6'd1;
        if (prs[KEY_P]) shadow_d.phase = shadow_q.phase + PHASE_STEP;  // wraps mod 512
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        live_d  = live_q;
        load_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_prs) begin
                    state_d = ST_PEND;
                    tmo_d   = '0;
                end
            end
            ST_PEND: begin
                // Further presses only accumulate; they never restart the timeout.
                if (bus.wrap_i || tmo_q == TMO_W'(TIMEOUT - 1)) state_d = ST_COMMIT;
                else                                            tmo_d   = tmo_q + 1'b1;
            end
            ST_COMMIT: begin
                // shadow_q excludes a press arriving this cycle; that press
                // opens a fresh pending window instead.
                live_d  = shadow_q;
                load_d  = 1'b1;
                tmo_d   = '0;
                state_d = any_prs ? ST_PEND : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        pend_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tmo_q    <= '0;
            shadow_q <= CFG_RST;
            live_q   <= CFG_RST;
            load_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            live_q   <= live_d;
            load_q   <= load_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.wave_sel    = live_q.wave;
    assign bus.amp         = live_q.amp;
    assign bus.freq_step   = live_q.freq;
    assign bus.phase_ofs   = live_q.phase;
    assign bus.cfg_load    = load_q;
    assign bus.cfg_pending = pend_q;
endmodule

// File: tb/tb_dds_cfg_scheduler.sv
// Bench for dds_cfg_scheduler with DEB_CYCLES=4, TIMEOUT=16, FREQ_MAX=50.
// Inputs are driven on the falling edge; outputs are compared on the
// following falling edge against a commit-window reference model.
module tb_dds_cfg_scheduler;
    localparam int DEB  = 4;
    localparam int TMO  = 16;
    localparam int FMAX = 50;
    localparam int LAT  = 2 + DEB;   // raw clean rise -> press cycle

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks, n_pass;

    dds_cfg_scheduler_if bus();

    dds_cfg_scheduler #(.DEB_CYCLES(DEB), .TIMEOUT(TMO), .FREQ_MAX(FMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // key drive state
    int       hold [4];
    int       low  [4];
    bit       ovr_en;
    bit [3:0] ovr_val;
    bit [3:0] sched [int];   // cycle -> expected press mask

    // reference model: shadow (m_*), live (l_*), open commit window
    int m_wave, m_amp, m_freq, m_phase;
    int l_wave, l_amp, l_freq, l_phase;
    bit win_open, exp_load;
    int win_start, commit_at;

    function automatic logic [22:0] obs();
        return {bus.wave_sel, bus.amp, bus.freq_step, bus.phase_ofs, bus.cfg_load, bus.cfg_pending};
    endfunction

    function automatic logic [22:0] expv();
        return {2'(l_wave), 4'(l_amp), 6'(l_freq), 9'(l_phase), exp_load, win_open};
    endfunction

    task automatic model_reset();
        m_wave = 0; m_amp = 1; m_freq = 1; m_phase = 0;
        l_wave = 0; l_amp = 1; l_freq = 1; l_phase = 0;
        win_open = 0; exp_load = 0; win_start = 0; commit_at = -1;
        sched.delete();
        for (int k = 0; k < 4; k++) begin hold[k] = 0; low[k] = 100; end
        ovr_en = 0; ovr_val = 4'b0;
        bus.key_w = 0; bus.key_a = 0; bus.key_p = 0; bus.key_f = 0; bus.wrap_i = 0;
    endtask

    task automatic start_press(input int k, input int h);
        bit [3:0] m;
        int at;
        at = cyc + LAT;
        m = sched.exists(at) ? sched[at] : 4'b0;
        m[k] = 1'b1;
        sched[at] = m;
        hold[k] = h;
    endtask

    // Drive this cycle's inputs, advance the model over it, move to next cycle.
    task automatic step(input bit wr);
        bit [3:0] kv, prs;
        for (int k = 0; k < 4; k++) begin
            kv[k] = (hold[k] > 0);
            if (hold[k] > 0) begin hold[k]--; low[k] = 0; end
            else low[k]++;
        end
        if (ovr_en) kv = ovr_val;
        bus.key_w = kv[0]; bus.key_a = kv[1]; bus.key_p = kv[2]; bus.key_f = kv[3];
        bus.wrap_i = wr;
        prs = 4'b0;
        if (sched.exists(cyc)) begin prs = sched[cyc]; sched.delete(cyc); end
        exp_load = 0;
        if (win_open && cyc == commit_at) begin
            l_wave = m_wave; l_amp = m_amp; l_freq = m_freq; l_phase = m_phase;
            exp_load = 1; win_open = 0;
        end else if (win_open && commit_at < 0 && cyc > win_start &&
                     (wr || cyc == win_start + TMO)) begin
            commit_at = cyc + 1;
        end
        if (prs[0]) m_wave  = (m_wave + 1) % 3;
        if (prs[1]) m_amp   = m_amp % 15 + 1;
        if (prs[3]) m_freq  = m_freq % FMAX + 1;
        if (prs[2]) m_phase = (m_phase + 64) % 512;
        if (prs != 0 && !win_open) begin
            win_open = 1; win_start = cyc; commit_at = -1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int loads = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs() !== {2'd0, 4'd1, 6'd1, 9'd0, 1'b0, 1'b0})
            $display("FAIL reset_hold got %h exp %h", obs(), {2'd0, 4'd1, 6'd1, 9'd0, 1'b0, 1'b0});
        else n_pass++;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(i % 8 == 7);
            loads += int'(bus.cfg_load);
            n_checks++;
            if (obs() !== expv()) $display("FAIL reset_idle cyc=%0d got %h exp %h", cyc, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if (loads !== 0) $display("FAIL reset_loads got %0d exp 0", loads);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int loads = 0;
        ovr_en = 1;
        for (int i = 0; i < 5; i++) begin
            ovr_val = (i % 2 == 0 && i < 3) ? 4'b0010 : 4'b0000;
            step(0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL bounce_glitch cyc=%0d got %h exp %h", cyc, obs(), expv());
            else n_pass++;
        end
        ovr_en = 0;
        start_press(1, 10);
        for (int i = 0; i < 40; i++) begin
            step(i % 8 == 7);
            loads += int'(bus.cfg_load);
            n_checks++;
            if (obs() !== expv()) $display("FAIL bounce cyc=%0d got %h exp %h", cyc, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if (loads !== 1 || bus.amp !== 4'd2)
            $display("FAIL bounce_result got loads=%0d amp=%0d exp loads=1 amp=2", loads, bus.amp);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int loads = 0;
        for (int i = 0; i < 48; i++) begin
            if (i == 0 || i == 8 || i == 16) start_press(3, 4);
            step(0);
            loads += int'(bus.cfg_load);
            n_checks++;
            if (obs() !== expv()) $display("FAIL timeout cyc=%0d got %h exp %h", cyc, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if (loads !== 1 || bus.freq_step !== 6'd4)
            $display("FAIL timeout_result got loads=%0d freq=%0d exp loads=1 freq=4", loads, bus.freq_step);
        else n_pass++;
    endtask

    task automatic test_phase_wave();
        for (int n = 0; n < 8; n++) begin
            start_press(2, 4);
            for (int i = 0; i < 20; i++) begin
                step(i == 10);
                n_checks++;
                if (obs() !== expv()) $display("FAIL phase cyc=%0d got %h exp %h", cyc, obs(), expv());
                else n_pass++;
            end
            n_checks++;
            if (bus.phase_ofs !== 9'(((n + 1) * 64) % 512))
                $display("FAIL phase_val got %0d exp %0d", bus.phase_ofs, ((n + 1) * 64) % 512);
            else n_pass++;
        end
        for (int n = 0; n < 3; n++) begin
            start_press(0, 4);
            for (int i = 0; i < 20; i++) begin
                step(i == 12);
                n_checks++;
                if (obs() !== expv()) $display("FAIL wave cyc=%0d got %h exp %h", cyc, obs(), expv());
                else n_pass++;
            end
            n_checks++;
            if (bus.wave_sel !== 2'((n + 1) % 3))
                $display("FAIL wave_val got %0d exp %0d", bus.wave_sel, (n + 1) % 3);
            else n_pass++;
        end
    endtask

    task automatic test_same_cycle();
        int w0, a0, f0;
        w0 = l_wave; a0 = l_amp; f0 = l_freq;
        for (int i = 0; i < 24; i++) begin
            if (i == 0) begin start_press(0, 6); start_press(3, 6); end
            if (i == 4) start_press(1, 6);        // lands in the COMMIT cycle
            step(i == 9 || i == 15);
            n_checks++;
            if (obs() !== expv()) $display("FAIL same_cycle cyc=%0d got %h exp %h", cyc, obs(), expv());
            else n_pass++;
            if (i == 10) begin
                n_checks++;
                if (bus.cfg_load !== 1'b1 || bus.cfg_pending !== 1'b1 ||
                    bus.wave_sel !== 2'((w0 + 1) % 3) || bus.freq_step !== 6'(f0 % FMAX + 1) ||
                    bus.amp !== 4'(a0))
                    $display("FAIL first_commit got ld=%0b pd=%0b w=%0d f=%0d a=%0d exp ld=1 pd=1 w=%0d f=%0d a=%0d",
                             bus.cfg_load, bus.cfg_pending, bus.wave_sel, bus.freq_step, bus.amp,
                             (w0 + 1) % 3, f0 % FMAX + 1, a0);
                else n_pass++;
            end
            if (i == 16) begin
                n_checks++;
                if (bus.cfg_load !== 1'b1 || bus.amp !== 4'(a0 % 15 + 1))
                    $display("FAIL second_commit got ld=%0b a=%0d exp ld=1 a=%0d", bus.cfg_load, bus.amp, a0 % 15 + 1);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_pend();
        int loads = 0;
        start_press(1, 4);
        for (int i = 0; i < 10; i++) begin
            step(0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL pre_reset cyc=%0d got %h exp %h", cyc, obs(), expv());
            else n_pass++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== {2'd0, 4'd1, 6'd1, 9'd0, 1'b0, 1'b0})
            $display("FAIL async_reset got %h exp %h", obs(), {2'd0, 4'd1, 6'd1, 9'd0, 1'b0, 1'b0});
        else n_pass++;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(i == 3 || i == 11);
            loads += int'(bus.cfg_load);
            n_checks++;
            if (obs() !== expv()) $display("FAIL post_reset cyc=%0d got %h exp %h", cyc, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if (loads !== 0) $display("FAIL post_reset_loads got %0d exp 0", loads);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++)
                if (hold[k] == 0 && low[k] >= DEB + 2 && $urandom_range(0, 19) == 0)
                    start_press(k, int'($urandom_range(DEB, DEB + 4)));
            step($urandom_range(0, 11) == 0);
            n_checks++;
            if (obs() !== expv()) $display("FAIL random cyc=%0d got %h exp %h", cyc, obs(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        n_checks = 0;
        n_pass = 0;
        bus.key_w = 0; bus.key_a = 0; bus.key_p = 0; bus.key_f = 0; bus.wrap_i = 0;
        test_reset();
        test_bounce();
        test_timeout();
        test_phase_wave();
        test_same_cycle();
        test_reset_pend();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
